// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Shadow/active digit registers give tear-free frame updates; adds blanking, guard and blink gating.
module seg_display_scanner #(
   parameter int SCAN_BITS    = 16,
   parameter int GUARD_CYCLES = 4,
   parameter int BLINK_BITS   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] bcd3,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd0,
   input  logic       colon,
   input  logic       blank_lz,
   input  logic       blink,
   output logic [7:0] seg,
   output logic [3:0] AN,
   output logic       updated
);

   localparam logic [SCAN_BITS-1:0] GUARD_LIMIT = SCAN_BITS'(GUARD_CYCLES);

   logic [3:0]            shadow3, shadow2, shadow1, shadow0;
   logic                  shadow_colon;
   logic                  pending;
   logic [3:0]            act3, act2, act1, act0;
   logic                  act_colon;
   logic [1:0]            index;
   logic [SCAN_BITS-1:0]  scan_count;
   logic [BLINK_BITS-1:0] blink_count;
   logic                  phase_on;

   logic       scan_wrap, boundary;
   logic       blank3, blank2, blank1;
   logic [3:0] cur_digit;
   logic       cur_blank, cur_dp;
   logic [7:0] next_seg;
   logic [3:0] next_an;

   // Active-low a..g patterns; codes above 9 show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   assign scan_wrap = (scan_count == '1);
   assign boundary  = scan_wrap && (index == 2'd3);

   // Blanking cascades from the leftmost digit; digit 0 always shows.
   always_comb begin
      blank3    = blank_lz && (act3 == 4'd0);
      blank2    = blank3 && (act2 == 4'd0);
      blank1    = blank2 && (act1 == 4'd0);
      cur_digit = act0;
      cur_blank = 1'b0;
      cur_dp    = 1'b1;
      case (index)
         2'd0: begin
            cur_digit = act0;
         end
         2'd1: begin
            cur_digit = act1;
            cur_blank = blank1;
         end
         2'd2: begin
            cur_digit = act2;
            cur_blank = blank2;
            cur_dp    = ~act_colon;
         end
         default: begin
            cur_digit = act3;
            cur_blank = blank3;
         end
      endcase
      next_seg = {cur_dp, cur_blank ? 7'h7F : decode(cur_digit)};
      next_an  = ~(4'b0001 << index);
      if ((scan_count < GUARD_LIMIT) || (blink && !phase_on)) begin
         next_seg = 8'hFF;
         next_an  = 4'hF;
      end
   end

   // A load in the boundary cycle bypasses the shadow so it lands in the very next frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow3      <= 4'd0;
         shadow2      <= 4'd0;
         shadow1      <= 4'd0;
         shadow0      <= 4'd0;
         shadow_colon <= 1'b0;
         pending      <= 1'b0;
         act3         <= 4'd0;
         act2         <= 4'd0;
         act1         <= 4'd0;
         act0         <= 4'd0;
         act_colon    <= 1'b0;
         index        <= 2'd0;
         scan_count   <= '0;
         blink_count  <= '0;
         phase_on     <= 1'b1;
         seg          <= 8'hFF;
         AN           <= 4'hF;
         updated      <= 1'b0;
      end else begin
         scan_count  <= scan_count + 1'b1;
         blink_count <= blink_count + 1'b1;
         if (scan_wrap)
            index <= index + 2'd1;
         if (blink_count == '1)
            phase_on <= ~phase_on;
         updated <= 1'b0;
         if (boundary) begin
            if (load) begin
               act3      <= bcd3;
               act2      <= bcd2;
               act1      <= bcd1;
               act0      <= bcd0;
               act_colon <= colon;
               pending   <= 1'b0;
               updated   <= 1'b1;
            end else if (pending) begin
               act3      <= shadow3;
               act2      <= shadow2;
               act1      <= shadow1;
               act0      <= shadow0;
               act_colon <= shadow_colon;
               pending   <= 1'b0;
               updated   <= 1'b1;
            end
         end else if (load) begin
            shadow3      <= bcd3;
            shadow2      <= bcd2;
            shadow1      <= bcd1;
            shadow0      <= bcd0;
            shadow_colon <= colon;
            pending      <= 1'b1;
         end
         seg <= next_seg;
         AN  <= next_an;
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed self-checking bench for seg_display_scanner with short scan/blink periods.
module tb_seg_display_scanner;

   localparam int SLOT  = 8;
   localparam int FRAME = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [3:0] bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
   logic       colon = 1'b0;
   logic       blank_lz = 1'b0;
   logic       blink = 1'b0;
   logic [7:0] seg;
   logic [3:0] an;
   logic       updated;

   int checks = 0;
   int failures = 0;
   int pos = -1;
   int upd_count = 0;
   int upd_base;
   int errs;
   int offs;

   seg_display_scanner #(
      .SCAN_BITS(3),
      .GUARD_CYCLES(1),
      .BLINK_BITS(6)
   ) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .bcd3(bcd3),
      .bcd2(bcd2),
      .bcd1(bcd1),
      .bcd0(bcd0),
      .colon(colon),
      .blank_lz(blank_lz),
      .blink(blink),
      .seg(seg),
      .AN(an),
      .updated(updated)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pos is the scan position the outputs currently reflect.
   task automatic step();
      @(posedge clk);
      #1;
      pos++;
      if (updated === 1'b1)
         upd_count++;
   endtask

   task automatic gotoSlot(input int idx, input int sc);
      do step(); while ((pos % FRAME) != (idx * SLOT + sc));
   endtask

   task automatic applyStimulus(input int idx, input int sc, input logic [3:0] d3, input logic [3:0] d2,
                                input logic [3:0] d1, input logic [3:0] d0, input logic c);
      gotoSlot(idx, sc);
      bcd3  = d3;
      bcd2  = d2;
      bcd1  = d1;
      bcd0  = d0;
      colon = c;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   task automatic checkDigit(input string tag, input int idx, input logic [7:0] exp);
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << idx);
      gotoSlot(idx, 4);
      checkOutput({tag, "_an"}, 32'(an), 32'(exp_an));
      checkOutput({tag, "_seg"}, 32'(seg), 32'(exp));
   endtask

   task automatic checkFrame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
      checkDigit({tag, "_d0"}, 0, e0);
      checkDigit({tag, "_d1"}, 1, e1);
      checkDigit({tag, "_d2"}, 2, e2);
      checkDigit({tag, "_d3"}, 3, e3);
   endtask

   function automatic logic [3:0] scanAn(input int p);
      if ((p % SLOT) == 0)
         scanAn = 4'hF;
      else
         scanAn = ~(4'b0001 << ((p / SLOT) % 4));
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_seg", 32'(seg), 32'hFF);
      checkOutput("rst_an", 32'(an), 32'hF);
      checkOutput("rst_upd", 32'(updated), 32'h0);

      reset = 1'b1;
      pos = -1;
      step();
      checkOutput("guard0_an", 32'(an), 32'hF);
      checkOutput("guard0_seg", 32'(seg), 32'hFF);
      step();
      checkOutput("slot0_first_an", 32'(an), 32'hE);
      checkOutput("slot0_first_seg", 32'(seg), 32'hC0);
      repeat (6) step();
      checkOutput("slot0_last_an", 32'(an), 32'hE);
      checkOutput("slot0_last_seg", 32'(seg), 32'hC0);
      step();
      checkOutput("guard1_an", 32'(an), 32'hF);
      step();
      checkOutput("slot1_an", 32'(an), 32'hD);
      gotoSlot(2, 1);
      checkOutput("slot2_an", 32'(an), 32'hB);
      gotoSlot(3, 1);
      checkOutput("slot3_an", 32'(an), 32'h7);

      upd_base = upd_count;
      applyStimulus(1, 2, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
      checkDigit("tf_old_d1", 1, 8'hC0);
      checkDigit("tf_old_d2", 2, 8'hC0);
      checkDigit("tf_old_d3", 3, 8'hC0);
      checkOutput("tf_no_early_upd", 32'(upd_count - upd_base), 32'd0);
      gotoSlot(3, 7);
      checkOutput("tf_upd_pulse", 32'(updated), 32'h1);
      checkFrame("tf_new", 8'h99, 8'hB0, 8'hA4, 8'hF9);
      checkOutput("tf_upd_once", 32'(upd_count - upd_base), 32'd1);

      blank_lz = 1'b1;
      applyStimulus(1, 2, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
      checkFrame("lz_0005", 8'h92, 8'hFF, 8'hFF, 8'hFF);
      applyStimulus(1, 2, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
      checkFrame("lz_0500", 8'hC0, 8'hC0, 8'h92, 8'hFF);
      applyStimulus(1, 2, 4'd0, 4'd3, 4'hC, 4'hF, 1'b1);
      checkFrame("colon_03CF", 8'hBF, 8'hBF, 8'h30, 8'hFF);
      applyStimulus(1, 2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
      checkFrame("colon_0000", 8'hC0, 8'hFF, 8'h7F, 8'hFF);

      // Blink phase is off whenever the position lies in an odd 64-cycle block.
      blink = 1'b1;
      errs = 0;
      offs = 0;
      repeat (128) begin
         step();
         if (((pos / 64) % 2) == 1) begin
            if (an !== 4'hF || seg !== 8'hFF)
               errs++;
         end else if (an !== scanAn(pos)) begin
            errs++;
         end
         if (an === 4'hF && seg === 8'hFF && (pos % SLOT) != 0)
            offs++;
      end
      checkOutput("blink_model_errs", 32'(errs), 32'd0);
      checkOutput("blink_dark_cycles", 32'(offs), 32'd56);

      blink = 1'b0;
      errs = 0;
      repeat (128) begin
         step();
         if (an !== scanAn(pos))
            errs++;
      end
      checkOutput("noblink_errs", 32'(errs), 32'd0);

      applyStimulus(3, 6, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
      checkOutput("bnd_upd", 32'(updated), 32'h1);
      step();
      checkOutput("bnd_upd_clear", 32'(updated), 32'h0);
      checkFrame("bnd_9999", 8'h90, 8'h90, 8'h90, 8'h90);
      upd_base = upd_count;
      gotoSlot(0, 4);
      checkOutput("bnd_no_pending", 32'(upd_count - upd_base), 32'd0);

      blank_lz = 1'b0;
      upd_base = upd_count;
      applyStimulus(1, 2, 4'd7, 4'd7, 4'd7, 4'd7, 1'b0);
      gotoSlot(2, 3);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      pos = -1;
      checkOutput("rst2_seg", 32'(seg), 32'hFF);
      checkOutput("rst2_an", 32'(an), 32'hF);
      checkOutput("rst2_upd", 32'(updated), 32'h0);
      checkFrame("rst2_frame", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      gotoSlot(0, 4);
      checkOutput("rst2_d0_next", 32'(seg), 32'hC0);
      checkOutput("rst2_no_upd", 32'(upd_count - upd_base), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexed driver for the 4-digit common-anode seven-segment display on the kitchen timer board. Sits at the receiving end of the timer core's digit interface: it accepts four BCD digits, a colon flag and a blink request via a load strobe, and drives the shared `seg`/`AN` lines. It provides tear-free frame updates, leading-zero blanking, an anti-ghosting guard interval and a blink gate.

## Interface
- `SCAN_BITS`, 16: each digit is shown for 2^SCAN_BITS clk cycles.
- `GUARD_CYCLES`, 4: cycles at the start of each digit slot with all anodes off. Must be < 2^SCAN_BITS.
- `BLINK_BITS`, 25: blink phase toggles every 2^BLINK_BITS clk cycles.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `load`  in  1  single-cycle strobe; captures `bcd3..bcd0` and `colon`.
- `bcd3`, `bcd2`, `bcd1`, `bcd0`  in  4 each  digit values; `bcd3` is the leftmost digit (`AN[3]`).
- `colon`  in  1  lights the decimal point on digit 2 (minutes/seconds separator).
- `blank_lz`  in  1  level; enables leading-zero blanking.
- `blink`  in  1  level; gates the display with the blink phase.
- `seg`  out  8  active-low cathodes: `seg[6:0]` = g,f,e,d,c,b,a; `seg[7]` = dp.
- `AN`  out  4  active-low anodes; one-hot low or all high.
- `updated`  out  1  one-cycle pulse when the shadow registers are copied into the active registers.

## Operation
- Reset (`reset`=0 on a clk edge) clears everything:
  - `seg`=8'hFF, `AN`=4'hF, `updated`=0.
  - Shadow and active digits = 0, colon = 0, `pending`=0.
  - Digit index = 0, scan counter = 0, blink counter = 0, blink phase = on.
  - Reset mid-frame discards any pending load.
- Load:
  - When `load`=1, the shadow registers take the digit and colon inputs, and `pending` is set.
  - A later load before the frame boundary overwrites the shadow (last value wins).
- Scan:
  - The scan counter increments every cycle.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Frame boundary (index=3 and scan counter at terminal count):
  - On the next cycle, index=0. If `pending`, active ← shadow, `pending` cleared, `updated`=1 for that cycle.
  - If `load` is asserted in the boundary cycle itself, its inputs go directly to active, `updated` pulses, and `pending` ends 0.
- Decode (0–9): standard active-low patterns, e.g. 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (bit 7=1).
- Decode (10–15): dash, seg=8'hBF.
- Leading-zero blanking (`blank_lz`=1):
  - Digit 3 blanks if it is 0.
  - Digit 2 blanks if digit 3 is blanked and digit 2 is 0.
  - Digit 1 blanks if digit 2 is blanked and digit 1 is 0.
  - Digit 0 never blanks.
  - A blanked digit has segments a–g off, but its anode is still driven.
- Colon: on digit 2, `seg[7]`=0 when active colon=1, independent of blanking.
- Blink:
  - The blink counter free-runs and toggles the phase on wrap.
  - While `blink`=1 and phase=off, `AN`=4'hF and `seg`=8'hFF.
  - `blink`=0 forces the display on; the counter keeps running.

## Timing
- `seg`, `AN` and `updated` are registered. The outputs in cycle n+1 reflect the index, scan counter, active registers and blink state in cycle n.
- Guard interval: while the scan counter < GUARD_CYCLES, `AN`=4'hF and `seg`=8'hFF.
- Otherwise `AN` is low only at bit `index`.
- Load-to-display latency:
  - Minimum 1 cycle after the boundary (load in the boundary cycle).
  - Maximum 4·2^SCAN_BITS + 1 cycles.
- Digits never mix old and new values within one frame.
- Inputs are synchronous to clk; there is no input synchronizer (the debouncer upstream supplies clean levels).

## Test plan
Bench parameters: SCAN_BITS=3, GUARD_CYCLES=1, BLINK_BITS=6.
- Reset and release:
  - Hold `reset`=0 for 3 cycles → `seg`=FF, `AN`=F, `updated`=0.
  - After release, the first slot shows `AN`=F for 1 cycle, then `AN`=1110 with `seg`=C0 for 7 cycles.
  - Slot order follows with `AN`=1101, 1011, 0111.
- Tear-free load:
  - Load 1,2,3,4 while index=1 → slots 1–3 of that frame still show C0.
  - `updated` pulses once at the wrap.
  - Next frame: digit 0 shows 99, 1 shows B0, 2 shows A4, 3 shows F9.
- Leading-zero blanking, `blank_lz`=1:
  - Load 0,0,0,5 → digits 3–1 show `seg`=FF with their anodes low; digit 0 shows 92.
  - Load 0,5,0,0 → digit 3 shows FF, digit 2 shows 92, digits 1 and 0 show C0.
- Colon and invalid codes:
  - Load 0,3,C,F with colon=1 → digit 2 shows 30; digits 1 and 0 show BF.
  - Load 0,0,0,0 with colon=1 and `blank_lz`=1 → digit 2 shows 7F.
- Blink:
  - `blink`=1 → `AN`=F and `seg`=FF for 64 consecutive cycles, alternating with 64 cycles of normal scan.
  - `blink`=0 → continuous scan.
- Boundary and reset corners:
  - Load 9,9,9,9 exactly in the boundary cycle → next cycle `updated`=1, and the new frame shows 90 on all digits.
  - Load 7,7,7,7 mid-frame, then pulse `reset` before the boundary → no `updated` pulse; the display stays C0.
